ledcube_scan_ctrl: RTL and testbench

LEDCUBE_SCAN_CTRL -- requirements
Module: ledcube_scan_ctrl

---
 rtl/ledcube_scan_ctrl.sv | 135 +++++++++++++
 tb/tb_ledcube_scan_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ledcube_scan_ctrl.sv
// Multiplexed LED-cube layer scanner: one layer lit per slot, with a frame
// buffer, an all-on lamp test and two animated plane patterns.
module ledcube_scan_ctrl #(
    parameter int N        = 3,
    parameter int SCAN_DIV = 50000
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   go,
    input  logic                   stop,
    input  logic                   ledtest,
    input  logic [1:0]             mode,
    input  logic                   step_tick,
    input  logic                   wr_en,
    input  logic [$clog2(N)-1:0]   wr_layer,
    input  logic [N*N-1:0]         wr_data,
    output logic [N-1:0]           layer_en,
    output logic [N*N-1:0]         row_on,
    output logic [1:0]             state,
    output logic                   frame_done
);

    localparam int LW = $clog2(N);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int W  = N * N;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TEST = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t          cur_state, state_nxt;
    logic [CW-1:0]   slot_cnt;
    logic [LW-1:0]   scan_layer, layer_nxt;
    logic [LW-1:0]   pos, pos_nxt;
    logic            dir_up, dir_nxt;
    logic [W-1:0]    row_pat, pat_nxt;
    logic [W-1:0]    frame_buf [N];
    logic            wrap, last_layer;

    assign wrap       = (slot_cnt == CW'(SCAN_DIV - 1));
    assign last_layer = (scan_layer == LW'(N - 1));
    assign layer_nxt  = last_layer ? '0 : scan_layer + LW'(1);
    assign state      = cur_state;

    always_comb begin
        state_nxt = cur_state;
        pos_nxt   = pos;
        dir_nxt   = dir_up;
        pat_nxt   = '0;

        case (cur_state)
            IDLE:    if (go) state_nxt = RUN; else if (ledtest) state_nxt = TEST;
            TEST:    if (!ledtest) state_nxt = IDLE;
            RUN:     if (stop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Bounce reverses at either end so the endpoints are shown only once per pass
        if (cur_state != RUN && state_nxt == RUN) begin
            pos_nxt = '0;
            dir_nxt = 1'b1;
        end else if (cur_state == RUN && step_tick) begin
            if (mode == 2'd1) begin
                pos_nxt = (pos == LW'(N - 1)) ? '0 : pos + LW'(1);
            end else if (mode == 2'd2) begin
                if (dir_up) begin
                    if (pos == LW'(N - 1)) begin
                        dir_nxt = 1'b0;
                        pos_nxt = pos - LW'(1);
                    end else begin
                        pos_nxt = pos + LW'(1);
                    end
                end else begin
                    if (pos == '0) begin
                        dir_nxt = 1'b1;
                        pos_nxt = pos + LW'(1);
                    end else begin
                        pos_nxt = pos - LW'(1);
                    end
                end
            end
        end

        case (state_nxt)
            TEST: pat_nxt = {W{1'b1}};
            RUN: begin
                if (mode == 2'd1 || mode == 2'd2)
                    pat_nxt = (layer_nxt == pos_nxt) ? {W{1'b1}} : '0;
                else
                    pat_nxt = frame_buf[layer_nxt];
            end
            default: pat_nxt = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur_state  <= IDLE;
            slot_cnt   <= '0;
            scan_layer <= '0;
            pos        <= '0;
            dir_up     <= 1'b1;
            row_pat    <= '0;
            layer_en   <= '0;
            row_on     <= '0;
            frame_done <= 1'b0;
        end else begin
            cur_state  <= state_nxt;
            pos        <= pos_nxt;
            dir_up     <= dir_nxt;
            slot_cnt   <= wrap ? '0 : slot_cnt + CW'(1);
            frame_done <= wrap && last_layer;
            // The slot's pattern is frozen at its start; its first cycle is blanked
            if (wrap) begin
                scan_layer <= layer_nxt;
                layer_en   <= (state_nxt == IDLE) ? '0 : (N'(1) << layer_nxt);
                row_pat    <= pat_nxt;
                row_on     <= '0;
            end else begin
                row_on     <= row_pat;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) frame_buf[i] <= '0;
        end else if (wr_en && int'(wr_layer) < N) begin
            frame_buf[wr_layer] <= wr_data;
        end
    end

endmodule

// File: tb/tb_ledcube_scan_ctrl.sv
// Bench for ledcube_scan_ctrl (N=3, SCAN_DIV=4): time-indexed reference model,
// per-cycle comparison, directed literal checks and a randomized soak.
module tb_ledcube_scan_ctrl;

    localparam int N  = 3;
    localparam int D  = 4;
    localparam int W  = N * N;
    localparam int LW = 2;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic           go = 1'b0, stop = 1'b0, ledtest = 1'b0, step_tick = 1'b0, wr_en = 1'b0;
    logic [1:0]     mode = 2'd0;
    logic [LW-1:0]  wr_layer = '0;
    logic [W-1:0]   wr_data = '0;
    logic [N-1:0]   layer_en;
    logic [W-1:0]   row_on;
    logic [1:0]     state;
    logic           frame_done;

    int tests = 0;
    int fails = 0;

    ledcube_scan_ctrl #(.N(N), .SCAN_DIV(D)) dut (
        .clock(clock), .reset_n(reset_n), .go(go), .stop(stop), .ledtest(ledtest),
        .mode(mode), .step_tick(step_tick), .wr_en(wr_en), .wr_layer(wr_layer),
        .wr_data(wr_data), .layer_en(layer_en), .row_on(row_on), .state(state),
        .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    // Reference model: everything is derived from the edge count since reset
    int            m_t, m_state, m_pos, nt, ns, lay;
    bit            m_up;
    logic [W-1:0]  m_fb [N];
    logic [W-1:0]  m_pat, exp_row;
    logic [N-1:0]  exp_layer_en;
    logic          exp_frame;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_t = 0; m_state = 0; m_pos = 0; m_up = 1'b1;
            for (int i = 0; i < N; i++) m_fb[i] = '0;
            m_pat = '0; exp_row = '0; exp_layer_en = '0; exp_frame = 1'b0;
        end else begin
            nt = m_t + 1;
            if (m_state == 0)      ns = go ? 2 : (ledtest ? 1 : 0);
            else if (m_state == 1) ns = ledtest ? 1 : 0;
            else                   ns = stop ? 0 : 2;
            if (m_state != 2 && ns == 2) begin
                m_pos = 0; m_up = 1'b1;
            end else if (m_state == 2 && step_tick) begin
                if (mode == 2'd1) begin
                    m_pos = (m_pos + 1) % N;
                end else if (mode == 2'd2) begin
                    if (m_up && m_pos == N - 1) m_up = 1'b0;
                    else if (!m_up && m_pos == 0) m_up = 1'b1;
                    m_pos = m_up ? m_pos + 1 : m_pos - 1;
                end
            end
            lay = (nt / D) % N;
            if (nt % D == 0) begin
                exp_layer_en = (ns == 0) ? '0 : N'(1 << lay);
                if (ns == 1)      m_pat = {W{1'b1}};
                else if (ns == 2) m_pat = (mode == 2'd1 || mode == 2'd2) ?
                                          ((lay == m_pos) ? {W{1'b1}} : '0) : m_fb[lay];
                else              m_pat = '0;
                exp_row = '0;
            end else begin
                exp_row = m_pat;
            end
            exp_frame = (nt % (D * N) == 0);
            if (wr_en && int'(wr_layer) < N) m_fb[wr_layer] = wr_data;
            m_state = ns;
            m_t = nt;
        end
    end

    task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        check_value("cyc_layer_en", 32'(layer_en), 32'(exp_layer_en));
        check_value("cyc_row_on", 32'(row_on), 32'(exp_row));
        check_value("cyc_state", 32'(state), 32'(m_state));
        check_value("cyc_frame_done", 32'(frame_done), 32'(exp_frame));
    end

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic do_reset(input bit check_now);
        #2 reset_n = 1'b0;
        #1;
        if (check_now) begin
            check_value("rst_layer_en", 32'(layer_en), 32'h0);
            check_value("rst_row_on", 32'(row_on), 32'h0);
            check_value("rst_state", 32'(state), 32'h0);
            check_value("rst_frame_done", 32'(frame_done), 32'h0);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic observe_lit(output int lit);
        lit = -1;
        repeat (D * N) begin
            run_cycles(1);
            if (row_on != '0)
                for (int i = 0; i < N; i++) if (layer_en[i]) lit = i;
        end
    endtask

    int exp1 [6] = '{1, 2, 0, 1, 2, 0};
    int exp2 [6] = '{1, 2, 1, 0, 1, 2};
    int lit;

    initial begin
        run_cycles(2);
        reset_n = 1'b1;

        // Plane sweep with no ticks: only layer 0 lights
        mode = 2'd1; go = 1'b1; run_cycles(1); go = 1'b0;
        check_value("a_state_run", 32'(state), 32'd2);
        run_cycles(3);
        check_value("a_t4_layer_en", 32'(layer_en), 32'b010);
        check_value("a_t4_row_on", 32'(row_on), 32'h0);
        run_cycles(1);
        check_value("a_t5_row_on", 32'(row_on), 32'h0);
        run_cycles(7);
        check_value("a_t12_frame_done", 32'(frame_done), 32'd1);
        check_value("a_t12_layer_en", 32'(layer_en), 32'b001);
        check_value("a_t12_row_on_blank", 32'(row_on), 32'h0);
        run_cycles(1);
        check_value("a_t13_row_on", 32'(row_on), 32'h1FF);
        check_value("a_t13_model_row", 32'(exp_row), 32'h1FF);
        check_value("a_t13_frame_done", 32'(frame_done), 32'd0);

        for (int k = 0; k < 6; k++) begin
            step_tick = 1'b1; run_cycles(1); step_tick = 1'b0;
            run_cycles(D * N);
            observe_lit(lit);
            check_value("sweep_pos", 32'(lit), 32'(exp1[k]));
        end
        stop = 1'b1; run_cycles(1); stop = 1'b0;
        mode = 2'd2; go = 1'b1; run_cycles(1); go = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step_tick = 1'b1; run_cycles(1); step_tick = 1'b0;
            run_cycles(D * N);
            observe_lit(lit);
            check_value("bounce_pos", 32'(lit), 32'(exp2[k]));
        end

        // go beats ledtest; lamp test then release
        do_reset(1'b1);
        go = 1'b1; ledtest = 1'b1; run_cycles(1); go = 1'b0; ledtest = 1'b0;
        check_value("c_go_priority", 32'(state), 32'd2);
        do_reset(1'b0);
        ledtest = 1'b1; run_cycles(1);
        check_value("c_state_test", 32'(state), 32'd1);
        run_cycles(4);
        check_value("c_test_row_on", 32'(row_on), 32'h1FF);
        check_value("c_test_layer_en", 32'(layer_en), 32'b010);
        ledtest = 1'b0; run_cycles(1);
        check_value("c_state_idle", 32'(state), 32'd0);
        run_cycles(2);
        check_value("c_idle_layer_en", 32'(layer_en), 32'h0);
        check_value("c_idle_row_on", 32'(row_on), 32'h0);

        // Frame buffer writes, out-of-range layer ignored
        do_reset(1'b0);
        wr_en = 1'b1; wr_layer = 2'd1; wr_data = 9'h0AA; run_cycles(1);
        wr_layer = 2'd2; wr_data = 9'h155; run_cycles(1);
        wr_layer = 2'd3; wr_data = 9'h1FF; run_cycles(1);
        wr_en = 1'b0; go = 1'b1; mode = 2'd0; run_cycles(1); go = 1'b0;
        run_cycles(1);
        check_value("e_layer1_row", 32'(row_on), 32'h0AA);
        check_value("e_layer1_en", 32'(layer_en), 32'b010);
        run_cycles(4);
        check_value("e_layer2_row", 32'(row_on), 32'h155);
        run_cycles(4);
        check_value("e_layer0_row", 32'(row_on), 32'h000);
        check_value("e_layer0_en", 32'(layer_en), 32'b001);

        // Mid-slot write to the scanned layer waits for its next slot
        wr_en = 1'b1; wr_layer = 2'd0; wr_data = 9'h123; run_cycles(1); wr_en = 1'b0;
        run_cycles(1);
        check_value("f_old_pattern_held", 32'(row_on), 32'h000);
        run_cycles(8);
        check_value("f_no_frame_done", 32'(frame_done), 32'd0);
        run_cycles(1);
        check_value("f_frame_done", 32'(frame_done), 32'd1);
        run_cycles(1);
        check_value("f_new_pattern", 32'(row_on), 32'h123);

        // Reset mid-run clears the buffer
        do_reset(1'b1);
        go = 1'b1; mode = 2'd0; run_cycles(1); go = 1'b0;
        run_cycles(12);
        check_value("g_cleared_en", 32'(layer_en), 32'b001);
        check_value("g_cleared_row", 32'(row_on), 32'h000);

        for (int c = 0; c < 4000; c++) begin
            go        = ($urandom % 8) == 0;
            stop      = ($urandom % 24) == 0;
            step_tick = ($urandom % 3) == 0;
            if ($urandom % 20 == 0) ledtest = ~ledtest;
            if ($urandom % 30 == 0) mode = 2'($urandom);
            wr_en     = ($urandom % 4) == 0;
            wr_layer  = LW'($urandom);
            wr_data   = W'($urandom);
            if ($urandom % 700 == 0) do_reset(1'b1);
            else run_cycles(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
